// File: rtl/dm_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_unit_if
// Description : Data-memory bus bundle between the load/store unit (master)
//               and the memory / interconnect (slave). Single outstanding
//               req/ack transfer, word-aligned address with byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_unit
// Description : MEM-stage load/store unit. Turns a decoded load/store into a
//               req/ack data-bus transfer, builds byte enables and replicated
//               store data, extends load data, and stalls the pipeline until
//               the access completes, is rejected as misaligned, or times out.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  wire              clk,
  input  wire              rstn,
  input  wire              req_valid,
  input  wire              mem_read,
  input  wire              mem_write,
  input  wire  [2:0]       dm_type,
  input  wire  [31:0]      addr,
  input  wire  [31:0]      wdata,
  output logic             stall,
  output logic [31:0]      ld_data,
  output logic             ld_valid,
  output logic             misalign,
  output logic             bus_err,
  dm_access_unit_if.master bus
);

  // Access size classes after folding the dm_type encoding.
  localparam logic [1:0] c_SZ_WORD = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_BYTE = 2'd2;

  // Last wait-counter value before the request is abandoned; the ack may
  // still land in that final cycle.
  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_op;
  logic        w_misal;
  logic        w_unsigned;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_cnt_last;

  logic        r_req;
  logic        r_we;
  logic [29:0] r_addr_hi;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic [31:0] r_ld_data;
  logic        r_ld_valid;
  logic        r_misal;
  logic        r_err;

  // A store wins when both read and write are flagged.
  assign w_op       = req_valid & (mem_read | mem_write);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  // Fold dm_type into size/signedness; reserved codes behave as word.
  always_comb begin
    w_size     = c_SZ_WORD;
    w_unsigned = 1'b0;
    case (dm_type)
      3'b001:  w_size = c_SZ_HALF;
      3'b010:  begin w_size = c_SZ_HALF; w_unsigned = 1'b1; end
      3'b011:  w_size = c_SZ_BYTE;
      3'b100:  begin w_size = c_SZ_BYTE; w_unsigned = 1'b1; end
      default: w_size = c_SZ_WORD;
    endcase
  end

  assign w_misal = ((w_size == c_SZ_WORD) && (addr[1:0] != 2'b00)) ||
                   ((w_size == c_SZ_HALF) && addr[0]);

  // Byte enables and lane-replicated store data for the incoming access.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (w_size)
      c_SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      c_SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the read data and extend it.
  always_comb begin
    w_byte = bus.bus_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_size)
      c_SZ_HALF: w_ext = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      c_SZ_BYTE: w_ext = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default:   w_ext = bus.bus_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and the combinational stall.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_op & ~w_misal;
        if (w_op && !w_misal) w_next = S_BUS;
      end
      S_BUS: begin
        stall = 1'b1;
        if (bus.bus_ack)     w_next = S_DONE;
        else if (w_cnt_last) w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus request registers, wait counter, load capture and status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr_hi  <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_size     <= c_SZ_WORD;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_misal    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ld_valid <= 1'b0;
      r_misal    <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_op && w_misal) begin
            r_misal <= 1'b1;
          end else if (w_op) begin
            r_req      <= 1'b1;
            r_we       <= mem_write;
            r_addr_hi  <= addr[31:2];
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_size     <= w_size;
            r_unsigned <= w_unsigned;
            r_off      <= addr[1:0];
            r_cnt      <= '0;
          end
        end
        S_BUS: begin
          if (bus.bus_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_ld_data  <= w_ext;
              r_ld_valid <= 1'b1;
            end
          end else if (w_cnt_last) begin
            r_req <= 1'b0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = {r_addr_hi, 2'b00};
  assign bus.bus_be    = r_be;
  assign bus.bus_wdata = r_wdata;
  assign ld_data       = r_ld_data;
  assign ld_valid      = r_ld_valid;
  assign misalign      = r_misal;
  assign bus_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_unit
// Description : Directed self-checking bench for dm_access_unit. A
//               transaction-level model tracks the last issued bus access and
//               the last load result; every cycle the DUT outputs are compared
//               against it. A second instance with a short timeout covers the
//               abort and last-cycle-ack cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid_t = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  dm_type = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic        stall, ld_valid, misalign, bus_err;
  logic [31:0] ld_data;
  logic        stall_t, ld_valid_t, misalign_t, bus_err_t;
  logic [31:0] ld_data_t;

  int checks = 0;
  int failures = 0;

  // Model state: the last issued access and the last load result.
  logic        m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [3:0]  m_be = 4'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_ld = 32'd0;

  // Per-cycle expectations.
  logic        exp_stall, exp_req, exp_we, exp_ldv, exp_mis, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;

  always #5 clk = ~clk;

  dm_access_unit_if bus ();
  dm_access_unit_if bus_t ();

  dm_access_unit #(.TIMEOUT(255)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus       (bus)
  );

  dm_access_unit #(.TIMEOUT(4)) dut_t (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid_t),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall_t),
    .ld_data   (ld_data_t),
    .ld_valid  (ld_valid_t),
    .misalign  (misalign_t),
    .bus_err   (bus_err_t),
    .bus       (bus_t)
  );

  // Access width in bytes; reserved dm_type codes are words.
  function automatic int nbytes(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] t, input logic [31:0] a);
    int n = nbytes(t);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] f_wd(input logic [2:0] t, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(t);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] f_ext(input logic [2:0] t, input logic [31:0] a,
                                        input logic [31:0] rd);
    int n = nbytes(t);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    logic [31:0] v = (rd >> (8*(a % 4))) & mask;
    if ((t == 3'd1 || t == 3'd3) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Quiet-cycle expectation: nothing pending, registers hold last access.
  task automatic set_idle();
    exp_stall = 1'b0; exp_req = 1'b0; exp_we = m_we; exp_addr = m_addr;
    exp_be = m_be; exp_wdata = m_wdata; exp_ldv = 1'b0; exp_ld = m_ld;
    exp_mis = 1'b0; exp_err = 1'b0;
  endtask

  task automatic compare();
    chk("stall",     32'(stall),         32'(exp_stall));
    chk("bus_req",   32'(bus.bus_req),   32'(exp_req));
    chk("bus_we",    32'(bus.bus_we),    32'(exp_we));
    chk("bus_addr",  bus.bus_addr,       exp_addr);
    chk("bus_be",    32'(bus.bus_be),    32'(exp_be));
    chk("bus_wdata", bus.bus_wdata,      exp_wdata);
    chk("ld_valid",  32'(ld_valid),      32'(exp_ldv));
    chk("ld_data",   ld_data,            exp_ld);
    chk("misalign",  32'(misalign),      32'(exp_mis));
    chk("bus_err",   32'(bus_err),       32'(exp_err));
  endtask

  // Compare the current cycle mid-period, then move to just after the next edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  // One load/store on the main instance; the bus acks after dly wait cycles.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] rdat);
    bit mis = (a % nbytes(ty)) != 0;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; dm_type = ty; addr = a; wdata = wd;
    set_idle(); exp_stall = !mis;
    tick();
    if (mis) begin
      req_valid = 1'b0;
      set_idle(); exp_mis = 1'b1;
      tick();
      set_idle();
      tick();
    end else begin
      m_we = wr; m_addr = {a[31:2], 2'b00}; m_be = f_be(ty, a); m_wdata = f_wd(ty, wd);
      for (int k = 0; k <= dly; k++) begin
        bus.bus_ack   = (k == dly);
        bus.bus_rdata = (k == dly) ? rdat : 32'hDEAD_BEEF;
        set_idle(); exp_stall = 1'b1; exp_req = 1'b1;
        tick();
      end
      bus.bus_ack = 1'b0;
      if (!wr) m_ld = f_ext(ty, a, rdat);
      // Completion cycle with the same instruction still presented.
      set_idle(); exp_ldv = !wr;
      tick();
      req_valid = 1'b0;
      set_idle();
      tick();
    end
  endtask

  initial begin
    bus.bus_ack = 1'b0;   bus.bus_rdata = 32'd0;
    bus_t.bus_ack = 1'b0; bus_t.bus_rdata = 32'd0;

    // Reset state.
    set_idle();
    @(negedge clk);
    compare();
    @(posedge clk); #1;
    rstn = 1'b1;
    set_idle();
    tick();

    // lb / lbu at byte lane 3.
    do_op(1'b1, 1'b0, 3'd3, 32'h0000_0103, 32'd0, 0, 32'h80FF_1234);
    chk("lb_be",   32'(bus.bus_be), 32'h8);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    do_op(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0, 0, 32'h80FF_1234);
    chk("lbu_data", ld_data, 32'h0000_0080);

    // sh to upper half.
    do_op(1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 0, 32'd0);
    chk("sh_addr",  bus.bus_addr, 32'h0000_0100);
    chk("sh_be",    32'(bus.bus_be), 32'hC);
    chk("sh_wdata", bus.bus_wdata, 32'hABCD_ABCD);
    chk("sh_we",    32'(bus.bus_we), 32'h1);
    chk("sh_keeps_ld", ld_data, 32'h0000_0080);

    // Misaligned word and half.
    do_op(1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'd0, 0, 32'd0);
    do_op(1'b0, 1'b1, 3'd1, 32'h0000_0003, 32'h1111_2222, 0, 32'd0);

    // lhu with a slow bus, then signed halves.
    do_op(1'b1, 1'b0, 3'd2, 32'h0000_0202, 32'd0, 5, 32'h9876_5432);
    chk("lhu_data", ld_data, 32'h0000_9876);
    do_op(1'b1, 1'b0, 3'd1, 32'h0000_0200, 32'd0, 1, 32'h1234_F00D);
    chk("lh_data", ld_data, 32'hFFFF_F00D);

    // sb lane 1, sw, read+write treated as store, reserved type as word.
    do_op(1'b0, 1'b1, 3'd3, 32'h0000_0001, 32'h1234_5678, 2, 32'd0);
    chk("sb_wdata", bus.bus_wdata, 32'h7878_7878);
    chk("sb_be",    32'(bus.bus_be), 32'h2);
    do_op(1'b0, 1'b1, 3'd0, 32'h0000_0004, 32'hCAFE_BABE, 0, 32'd0);
    do_op(1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'h0000_5A5A, 0, 32'hFFFF_FFFF);
    chk("rw_is_store", 32'(bus.bus_we), 32'h1);
    do_op(1'b1, 1'b0, 3'd7, 32'h0000_0008, 32'd0, 0, 32'h55AA_55AA);
    chk("rsv_word", ld_data, 32'h55AA_55AA);
    do_op(1'b1, 1'b0, 3'd3, 32'h0000_0002, 32'd0, 0, 32'h007F_0000);
    chk("lb_pos", ld_data, 32'h0000_007F);

    // Unqualified read and stray ack are both ignored.
    req_valid = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h0BAD_0BAD;
    set_idle();
    tick();
    bus.bus_ack = 1'b0;
    tick();

    // Timeout instance: no ack, request abandoned after 4 wait cycles.
    req_valid_t = 1'b1; mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'd0; addr = 32'h40;
    set_idle();
    tick();
    req_valid_t = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("to_req",   32'(bus_t.bus_req), 32'h1);
      chk("to_stall", 32'(stall_t), 32'h1);
      chk("to_err0",  32'(bus_err_t), 32'h0);
      tick();
    end
    chk("to_req_drop", 32'(bus_t.bus_req), 32'h0);
    chk("to_err",      32'(bus_err_t), 32'h1);
    chk("to_no_ldv",   32'(ld_valid_t), 32'h0);
    tick();
    chk("to_err_once", 32'(bus_err_t), 32'h0);
    chk("to_idle_stall", 32'(stall_t), 32'h0);

    // Timeout instance: ack in the 4th wait cycle is honoured.
    req_valid_t = 1'b1;
    tick();
    req_valid_t = 1'b0;
    tick(); tick(); tick();
    bus_t.bus_ack = 1'b1; bus_t.bus_rdata = 32'h1122_3344;
    tick();
    bus_t.bus_ack = 1'b0;
    chk("late_ldv",  32'(ld_valid_t), 32'h1);
    chk("late_err",  32'(bus_err_t), 32'h0);
    chk("late_data", ld_data_t, 32'h1122_3344);
    chk("late_req",  32'(bus_t.bus_req), 32'h0);
    tick();

    // Reset in the middle of a transfer.
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'd0; addr = 32'h300;
    set_idle(); exp_stall = 1'b1;
    tick();
    chk("rst_pre_req", 32'(bus.bus_req), 32'h1);
    req_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_req",   32'(bus.bus_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_addr",  bus.bus_addr, 32'h0);
    chk("rst_ld",    ld_data, 32'h0);
    chk("rst_be",    32'(bus.bus_be), 32'h0);
    m_we = 1'b0; m_addr = 32'd0; m_be = 4'd0; m_wdata = 32'd0; m_ld = 32'd0;
    set_idle();
    @(negedge clk);
    compare();
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    tick();

    // Fresh load after reset.
    do_op(1'b1, 1'b0, 3'd2, 32'h0000_0022, 32'd0, 0, 32'hC3C3_0000);
    chk("post_rst_lhu", ld_data, 32'h0000_C3C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
